// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, talks req/ack to imem, buffers words in a prefetch FIFO.
// Define FETCH_PERF_EN to add the o_perf_starve / o_perf_drop counters.
module fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                DEPTH      = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_req,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_data,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       o_perf_starve,
    output logic [15:0]       o_perf_drop
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] hold_q;
    logic [ADDR_W-1:0] hold_d;

    fetch_entry_t      fifo_q [DEPTH];
    logic [PW-1:0]     wr_q;
    logic [PW-1:0]     rd_q;
    logic [CW-1:0]     count_q;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              push;
    logic              pop;
    logic              drop;
    logic              valid;

    assign valid = (count_q != '0);
    assign pop   = valid && i_instr_ready && !i_redirect;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        req     = 1'b0;
        addr    = pc_q;
        push    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            RUN: begin
                // eligibility uses occupancy before any pop this cycle
                req  = (count_q < FULL);
                addr = pc_q;
                if (i_redirect) begin
                    pc_d = i_redirect_addr;
                    if (req && !i_imem_ack) begin
                        hold_d  = pc_q;
                        state_d = DRAIN;
                    end else if (req && i_imem_ack) begin
                        drop = 1'b1;
                    end
                end else if (req && i_imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // the abandoned request must complete before a new one goes out
                req  = 1'b1;
                addr = hold_q;
                if (i_redirect) begin
                    pc_d = i_redirect_addr;
                end
                if (i_imem_ack) begin
                    drop    = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_ADDR;
            hold_q  <= RESET_ADDR;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            if (i_redirect) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_q <= wr_q + 1'b1;
                end
                if (pop) begin
                    rd_q <= rd_q + 1'b1;
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_n && push) begin
            fifo_q[wr_q] <= '{data: i_imem_data, pc: pc_q};
        end
    end

    // reset gates the handshake outputs so nothing leaks before the first edge
    assign o_imem_req    = i_reset_n && req;
    assign o_imem_addr   = i_reset_n ? addr : RESET_ADDR;
    assign o_instr_valid = i_reset_n && valid;
    assign o_instr       = fifo_q[rd_q].data;
    assign o_instr_pc    = fifo_q[rd_q].pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            o_perf_starve <= '0;
            o_perf_drop   <= '0;
        end else begin
            if (i_instr_ready && !valid && o_perf_starve != 16'hFFFF) begin
                o_perf_starve <= o_perf_starve + 16'd1;
            end
            if (drop && o_perf_drop != 16'hFFFF) begin
                o_perf_drop <= o_perf_drop + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a sequence-level model (pc continuity, mem contents).
module tb_fetch_unit;

    logic        i_clock;
    logic        i_reset_n;
    logic [15:0] o_imem_addr;
    logic        o_imem_req;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic [15:0] o_instr;
    logic [15:0] o_instr_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_redirect;
    logic [15:0] i_redirect_addr;
`ifdef FETCH_PERF_EN
    logic [15:0] o_perf_starve;
    logic [15:0] o_perf_drop;
`endif

    fetch_unit #(
        .ADDR_W(16),
        .DATA_W(16),
        .DEPTH(2),
        .RESET_ADDR(16'h0000)
    ) dut (
        .i_clock(i_clock),
        .i_reset_n(i_reset_n),
        .o_imem_addr(o_imem_addr),
        .o_imem_req(o_imem_req),
        .i_imem_ack(i_imem_ack),
        .i_imem_data(i_imem_data),
        .o_instr(o_instr),
        .o_instr_pc(o_instr_pc),
        .o_instr_valid(o_instr_valid),
        .i_instr_ready(i_instr_ready),
        .i_redirect(i_redirect),
        .i_redirect_addr(i_redirect_addr)
`ifdef FETCH_PERF_EN
        ,
        .o_perf_starve(o_perf_starve),
        .o_perf_drop(o_perf_drop)
`endif
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    assign i_imem_data = memf(o_imem_addr);

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    int tests = 0;
    int fails = 0;

    logic        rst_n;
    logic        rdy;
    logic        redir;
    logic [15:0] raddr;
    logic        ack_ovr;
    logic        ack_val;
    int          lat;
    int          wait_cnt;

    logic        s_req;
    logic [15:0] s_addr;
    logic        s_ack;
    logic        s_valid;
    logic [15:0] s_instr;
    logic [15:0] s_pc;
    logic        s_xfer;
    logic        s_accept;

    // One clock cycle: drive inputs, model memory, sample, cross the posedge.
    task automatic step();
        i_reset_n       = rst_n;
        i_instr_ready   = rdy;
        i_redirect      = redir;
        i_redirect_addr = raddr;
        #1;
        s_req  = o_imem_req;
        s_addr = o_imem_addr;
        if (ack_ovr) s_ack = ack_val;
        else s_ack = s_req && (wait_cnt >= lat);
        i_imem_ack = s_ack;
        #1;
        s_valid  = o_instr_valid;
        s_instr  = o_instr;
        s_pc     = o_instr_pc;
        s_xfer   = s_req && s_ack;
        s_accept = s_valid && rdy;
        if (!rst_n || s_xfer || !s_req) wait_cnt = 0;
        else wait_cnt++;
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        redir   = 1'b0;
        ack_ovr = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redir = 1'b0; rdy = 1'b1; lat = 0;
        step();
        step();
        tests++;
        if (s_req !== 1'b0 || s_valid !== 1'b0 || s_addr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_outputs: req=%b valid=%b addr=%h, required 0 0 0000",
                     s_req, s_valid, s_addr);
        end
`ifdef FETCH_PERF_EN
        tests++;
        if (o_perf_starve !== 16'h0 || o_perf_drop !== 16'h0) begin
            fails++;
            $display("FAIL reset_perf: starve=%h drop=%h, required 0000 0000",
                     o_perf_starve, o_perf_drop);
        end
`endif
        rst_n = 1'b1;
        step();
        tests++;
        if (s_req !== 1'b1 || s_addr !== 16'h0000 || s_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: req=%b addr=%h valid=%b, required 1 0000 0",
                     s_req, s_addr, s_valid);
        end
    endtask

    task automatic test_stream();
        lat = 0; rdy = 1'b1;
        do_reset();
        step();
        tests++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 16'h0000) begin
            fails++;
            $display("FAIL stream_first: valid=%b req=%b addr=%h, required 0 1 0000",
                     s_valid, s_req, s_addr);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if (s_valid !== 1'b1 || s_pc !== 16'(i) || s_instr !== memf(16'(i))) begin
                fails++;
                $display("FAIL stream_word %0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         i, s_valid, s_pc, s_instr, 16'(i), memf(16'(i)));
            end
            tests++;
            if (s_req !== 1'b1 || s_addr !== 16'(i + 1)) begin
                fails++;
                $display("FAIL stream_req %0d: req=%b addr=%h, required 1 %h",
                         i, s_req, s_addr, 16'(i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        int xf;
        lat = 0; rdy = 1'b0; xf = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            xf += int'(s_xfer);
            if (i >= 2) begin
                tests++;
                if (s_req !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_req_low %0d: req=%b, required 0", i, s_req);
                end
            end
            if (i >= 1) begin
                tests++;
                if (s_valid !== 1'b1 || s_pc !== 16'h0000 || s_instr !== memf(16'h0000)) begin
                    fails++;
                    $display("FAIL bp_head_stable %0d: valid=%b pc=%h instr=%h, required 1 0000 %h",
                             i, s_valid, s_pc, s_instr, memf(16'h0000));
                end
            end
        end
        tests++;
        if (xf !== 2) begin
            fails++;
            $display("FAIL bp_buffered: transfers=%0d, required 2", xf);
        end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (s_accept !== 1'b1 || s_pc !== 16'(i) || s_instr !== memf(16'(i))) begin
                fails++;
                $display("FAIL bp_order %0d: accept=%b pc=%h instr=%h, required 1 %h %h",
                         i, s_accept, s_pc, s_instr, 16'(i), memf(16'(i)));
            end
        end
    endtask

    task automatic test_redirect_pending();
        logic drained;
        logic found;
        lat = 3; rdy = 1'b1;
        do_reset();
        step();
        tests++;
        if (s_req !== 1'b1 || s_xfer !== 1'b0) begin
            fails++;
            $display("FAIL rp_pending: req=%b xfer=%b, required 1 0", s_req, s_xfer);
        end
        redir = 1'b1; raddr = 16'h0040;
        step();
        redir = 1'b0;
        drained = 1'b0;
        for (int k = 0; k < 10 && !drained; k++) begin
            step();
            tests++;
            if (s_req !== 1'b1 || s_addr !== 16'h0000 || s_valid !== 1'b0) begin
                fails++;
                $display("FAIL rp_drain %0d: req=%b addr=%h valid=%b, required 1 0000 0",
                         k, s_req, s_addr, s_valid);
            end
            if (s_xfer) drained = 1'b1;
        end
        tests++;
        if (!drained) begin
            fails++;
            $display("FAIL rp_drain_timeout: drained=0, required 1");
        end
        step();
        tests++;
        if (s_req !== 1'b1 || s_addr !== 16'h0040) begin
            fails++;
            $display("FAIL rp_next_addr: req=%b addr=%h, required 1 0040", s_req, s_addr);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (s_valid) begin
                found = 1'b1;
                tests++;
                if (s_pc !== 16'h0040 || s_instr !== memf(16'h0040)) begin
                    fails++;
                    $display("FAIL rp_first_valid: pc=%h instr=%h, required 0040 %h",
                             s_pc, s_instr, memf(16'h0040));
                end
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL rp_valid_timeout: found=0, required 1");
        end
`ifdef FETCH_PERF_EN
        tests++;
        if (o_perf_drop !== 16'd1) begin
            fails++;
            $display("FAIL rp_perf_drop: drop=%0d, required 1", o_perf_drop);
        end
`endif
        lat = 0;
    endtask

    task automatic test_redirect_ack_pop();
        lat = 0; rdy = 1'b0;
        do_reset();
        step();
        rdy = 1'b1; redir = 1'b1; raddr = 16'h1234;
        step();
        tests++;
        if (s_valid !== 1'b1 || s_xfer !== 1'b1) begin
            fails++;
            $display("FAIL rap_setup: valid=%b xfer=%b, required 1 1", s_valid, s_xfer);
        end
        redir = 1'b0; rdy = 1'b0;
        step();
        tests++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 16'h1234) begin
            fails++;
            $display("FAIL rap_flush: valid=%b req=%b addr=%h, required 0 1 1234",
                     s_valid, s_req, s_addr);
        end
        rdy = 1'b1;
        step();
        tests++;
        if (s_valid !== 1'b1 || s_pc !== 16'h1234 || s_instr !== memf(16'h1234)) begin
            fails++;
            $display("FAIL rap_head: valid=%b pc=%h instr=%h, required 1 1234 %h",
                     s_valid, s_pc, s_instr, memf(16'h1234));
        end
`ifdef FETCH_PERF_EN
        tests++;
        if (o_perf_drop !== 16'd1) begin
            fails++;
            $display("FAIL rap_perf_drop: drop=%0d, required 1", o_perf_drop);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [15:0] wexp [4];
        int got;
        wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
        lat = 0; rdy = 1'b1;
        do_reset();
        step();
        step();
        redir = 1'b1; raddr = 16'hFFFE;
        step();
        redir = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && got < 4; k++) begin
            step();
            if (s_accept) begin
                tests++;
                if (s_pc !== wexp[got] || s_instr !== memf(wexp[got])) begin
                    fails++;
                    $display("FAIL wrap_pc %0d: pc=%h instr=%h, required %h %h",
                             got, s_pc, s_instr, wexp[got], memf(wexp[got]));
                end
                got++;
            end
        end
        tests++;
        if (got !== 4) begin
            fails++;
            $display("FAIL wrap_count: got=%0d, required 4", got);
        end
    endtask

    task automatic test_reset_mid();
        lat = 0; rdy = 1'b1;
        do_reset();
        step(); step(); step();
        lat = 20;
        step();
        step();
        tests++;
        if (s_req !== 1'b1 || s_xfer !== 1'b0 || s_addr === 16'h0000) begin
            fails++;
            $display("FAIL rm_pending: req=%b xfer=%b addr=%h, required 1 0 nonzero",
                     s_req, s_xfer, s_addr);
        end
        rst_n = 1'b0; ack_ovr = 1'b1; ack_val = 1'b1;
        step();
        tests++;
        if (s_req !== 1'b0 || s_valid !== 1'b0 || s_addr !== 16'h0000) begin
            fails++;
            $display("FAIL rm_in_reset: req=%b valid=%b addr=%h, required 0 0 0000",
                     s_req, s_valid, s_addr);
        end
        rst_n = 1'b1; ack_ovr = 1'b0;
        step();
        tests++;
        if (s_req !== 1'b1 || s_addr !== 16'h0000 || s_valid !== 1'b0) begin
            fails++;
            $display("FAIL rm_after: req=%b addr=%h valid=%b, required 1 0000 0",
                     s_req, s_addr, s_valid);
        end
        step();
        tests++;
        if (s_valid !== 1'b0) begin
            fails++;
            $display("FAIL rm_stale_ack: valid=%b, required 0", s_valid);
        end
        lat = 0;
    endtask

    // Model: accepted words form runs pc, pc+1, ... restarting at each redirect target.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic        p_pend;
        logic [15:0] p_addr;
        int          starve_m;
        int          accepts;
        lat = 0; rdy = 1'b1;
        do_reset();
        exp_pc = 16'h0000; p_pend = 1'b0; p_addr = '0;
        starve_m = 0; accepts = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) raddr = 16'hFFFC + 16'($urandom_range(0, 3));
            else raddr = 16'($urandom);
            step();
            if (p_pend) begin
                tests++;
                if (s_req !== 1'b1 || s_addr !== p_addr) begin
                    fails++;
                    $display("FAIL rand_req_hold %0d: req=%b addr=%h, required 1 %h",
                             c, s_req, s_addr, p_addr);
                end
            end
            p_pend = s_req && !s_xfer;
            p_addr = s_addr;
            if (s_xfer) lat = $urandom_range(0, 3);
            if (rdy && !s_valid) starve_m++;
            if (s_accept && !redir) begin
                tests++;
                if (s_pc !== exp_pc || s_instr !== memf(exp_pc)) begin
                    fails++;
                    $display("FAIL rand_word %0d: pc=%h instr=%h, required %h %h",
                             c, s_pc, s_instr, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 16'd1;
                accepts++;
            end
            if (redir) exp_pc = raddr;
        end
        redir = 1'b0;
        tests++;
        if (accepts < 300) begin
            fails++;
            $display("FAIL rand_progress: accepts=%0d, required >= 300", accepts);
        end
`ifdef FETCH_PERF_EN
        tests++;
        if (o_perf_starve !== 16'(starve_m)) begin
            fails++;
            $display("FAIL rand_perf_starve: starve=%0d, required %0d", o_perf_starve, starve_m);
        end
`endif
        lat = 0;
    endtask

    initial begin
        i_reset_n = 1'b0; i_imem_ack = 1'b0; i_instr_ready = 1'b0;
        i_redirect = 1'b0; i_redirect_addr = '0;
        rst_n = 1'b0; rdy = 1'b0; redir = 1'b0; raddr = '0;
        ack_ovr = 1'b0; ack_val = 1'b0; lat = 0; wait_cnt = 0;
        @(negedge i_clock);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_pending();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

endmodule
